// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a register-init LUT and issues one I2C write per entry with delays and NACK retry.
// Define I2C_CFG_WDT_EN to add a 2**20-cycle request watchdog that times out as a NACK.
module i2c_cfg_sequencer #(
    parameter int         INDEX_W        = 10,
    parameter int         REG_ADDR_BYTES = 2,
    parameter int         DELAY_UNIT_CYC = 50000,
    parameter int         GAP_CYC        = 16,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] END_DEV        = 8'hFF,
    parameter logic [7:0] DELAY_DEV      = 8'hFE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [INDEX_W-1:0] lut_index,
    input  logic [31:0]        lut_data,
    output logic               i2c_req,
    output logic [7:0]         i2c_dev,
    output logic [15:0]        i2c_reg,
    output logic               i2c_reg_2b,
    output logic [7:0]         i2c_data,
    input  logic               i2c_done,
    input  logic               i2c_nack,
    output logic               busy,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [INDEX_W-1:0] err_index
);
    localparam int DLY_W = $clog2(255 * DELAY_UNIT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, GAP, DELAY, FINISH, FAIL} state_t;

    state_t             state, state_n, adv_state;
    logic [INDEX_W-1:0] idx_n, adv_idx, eidx_n;
    logic               req_n, reg2b_n, last, nack, xfer_end, tmo;
    logic [7:0]         dev_n, data_n;
    logic [15:0]        reg_n;
    logic [RTY_W-1:0]   rty_cnt, rty_n;
    logic [DLY_W-1:0]   dly_cnt, dly_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;

    // Advancing past the last table slot ends the sequence instead of wrapping.
    assign last      = &lut_index;
    assign adv_state = last ? FINISH : FETCH;
    assign adv_idx   = last ? lut_index : lut_index + 1'b1;
    assign xfer_end  = i2c_done || tmo;
    assign nack      = i2c_done ? i2c_nack : tmo;

`ifdef I2C_CFG_WDT_EN
    logic [19:0] wdt_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdt_cnt <= '0;
        else        wdt_cnt <= (state == WRITE && !i2c_done) ? wdt_cnt + 1'b1 : '0;
    end
    assign tmo = (state == WRITE) && !i2c_done && (&wdt_cnt);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        idx_n   = lut_index;
        req_n   = i2c_req;
        dev_n   = i2c_dev;
        reg_n   = i2c_reg;
        data_n  = i2c_data;
        reg2b_n = i2c_reg_2b;
        eidx_n  = err_index;
        rty_n   = rty_cnt;
        dly_n   = dly_cnt;
        gap_n   = gap_cnt;
        case (state)
            IDLE, FINISH, FAIL: begin
                if (start) begin
                    state_n = FETCH;
                    idx_n   = '0;
                    eidx_n  = '0;
                    rty_n   = '0;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                if (lut_data[31:24] == END_DEV) begin
                    state_n = FINISH;
                end else if (lut_data[31:24] == DELAY_DEV) begin
                    if (lut_data[7:0] == 8'd0) begin
                        state_n = adv_state;
                        idx_n   = adv_idx;
                    end else begin
                        state_n = DELAY;
                        dly_n   = DLY_W'(lut_data[7:0]) * DLY_W'(DELAY_UNIT_CYC) - DLY_W'(1);
                    end
                end else begin
                    state_n = WRITE;
                    req_n   = 1'b1;
                    dev_n   = lut_data[31:24];
                    reg_n   = (REG_ADDR_BYTES == 2) ? lut_data[23:8] : {8'h00, lut_data[23:16]};
                    data_n  = lut_data[7:0];
                    reg2b_n = (REG_ADDR_BYTES == 2);
                end
            end
            WRITE: begin
                if (xfer_end) begin
                    req_n = 1'b0;
                    if (nack && rty_cnt >= RTY_W'(MAX_RETRY)) begin
                        state_n = FAIL;
                        eidx_n  = lut_index;
                    end else begin
                        state_n = GAP;
                        gap_n   = GAP_W'(GAP_CYC - 1);
                        rty_n   = nack ? rty_cnt + 1'b1 : '0;
                    end
                end
            end
            // A non-zero retry count means the same entry is fetched and issued again.
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n = (rty_cnt == '0) ? adv_state : FETCH;
                    idx_n   = (rty_cnt == '0) ? adv_idx : lut_index;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            DELAY: begin
                if (dly_cnt == '0) begin
                    state_n = adv_state;
                    idx_n   = adv_idx;
                end else begin
                    dly_n = dly_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lut_index  <= '0;
            i2c_req    <= 1'b0;
            i2c_dev    <= '0;
            i2c_reg    <= '0;
            i2c_reg_2b <= 1'b0;
            i2c_data   <= '0;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            err_index  <= '0;
            rty_cnt    <= '0;
            dly_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            lut_index  <= idx_n;
            i2c_req    <= req_n;
            i2c_dev    <= dev_n;
            i2c_reg    <= reg_n;
            i2c_reg_2b <= reg2b_n;
            i2c_data   <= data_n;
            busy       <= !(state_n == IDLE || state_n == FINISH || state_n == FAIL);
            cfg_done   <= (state_n == FINISH);
            cfg_err    <= (state_n == FAIL);
            err_index  <= eidx_n;
            rty_cnt    <= rty_n;
            dly_cnt    <= dly_n;
            gap_cnt    <= gap_n;
        end
    end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: directed bench with an 8-entry registered LUT model and an I2C slave responder.
module tb_i2c_cfg_sequencer;
    localparam int IW = 3;

    typedef struct {
        logic [31:0] entry;
        logic [7:0]  dev;
        logic [15:0] rg;
        logic [7:0]  dat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] lut_index;
    logic [31:0]   lut_data;
    logic          i2c_req, i2c_reg_2b, i2c_done, i2c_nack, busy, cfg_done, cfg_err;
    logic [7:0]    i2c_dev, i2c_data;
    logic [15:0]   i2c_reg;
    logic [IW-1:0] err_index;

    logic [31:0] lut [8];
    int          nack_cfg [8];
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    bit          spur_en = 1'b0;

    int          seen_epoch, n_log, stab_err, cnt;
    int          reqs_at [8];
    int          log_idx [16];
    logic [7:0]  log_dev [16];
    logic [7:0]  log_dat [16];
    logic [15:0] log_reg [16];
    logic [7:0]  cap_dev, cap_dat;
    logic [15:0] cap_reg;
    logic        prev_req;

    i2c_cfg_sequencer #(
        .INDEX_W(IW), .REG_ADDR_BYTES(2), .DELAY_UNIT_CYC(10), .GAP_CYC(4), .MAX_RETRY(3),
        .END_DEV(8'hFF), .DELAY_DEV(8'hFE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_index(lut_index), .lut_data(lut_data),
        .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_reg_2b(i2c_reg_2b),
        .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // LUT with one cycle of read latency
    always @(posedge clk) lut_data <= lut[lut_index];

    // Slave: done 4 cycles into each request; NACKs the first nack_cfg[idx] requests of an entry
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        seen_epoch = 0;
        n_log = 0;
        stab_err = 0;
        cnt = 0;
        prev_req = 1'b0;
        foreach (reqs_at[i]) reqs_at[i] = 0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (seen_epoch != epoch) begin
                seen_epoch = epoch;
                n_log = 0;
                stab_err = 0;
                foreach (reqs_at[i]) reqs_at[i] = 0;
            end
            if (!i2c_req) begin
                cnt = 0;
                if (prev_req && spur_en) begin
                    i2c_done = 1'b1;
                    i2c_nack = 1'b1;
                end
            end else begin
                cnt++;
                if (cnt == 1) begin
                    reqs_at[lut_index]++;
                    cap_dev = i2c_dev;
                    cap_reg = i2c_reg;
                    cap_dat = i2c_data;
                    if (n_log < 16) begin
                        log_idx[n_log] = int'(lut_index);
                        log_dev[n_log] = i2c_dev;
                        log_reg[n_log] = i2c_reg;
                        log_dat[n_log] = i2c_data;
                        n_log++;
                    end
                end else if (i2c_dev !== cap_dev || i2c_reg !== cap_reg || i2c_data !== cap_dat) begin
                    stab_err++;
                end
                if (cnt == 4) begin
                    i2c_done = 1'b1;
                    i2c_nack = (reqs_at[lut_index] <= nack_cfg[lut_index]);
                    cnt = 0;
                end
            end
            prev_req = i2c_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        while (!((cfg_done || cfg_err) && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_end: still busy=%b after %0d cycles, required idle", nm, busy, n);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!i2c_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_req: no request after %0d cycles, required one", nm, n);
        end
    endtask

    task automatic delay_run(input logic [7:0] units, input int exp_idx, input int exp_req);
        int k = 0;
        int first_idx = -1;
        int first_req = -1;
        lut[0] = {24'hFE0000, units};
        lut[1] = 32'h78310311;
        lut[2] = 32'hFF000000;
        epoch++;
        pulse_start();
        while (first_req < 0 && k < 3000) begin
            @(negedge clk);
            k++;
            if (first_idx < 0 && lut_index == 3'd1) first_idx = k;
            if (i2c_req) first_req = k;
        end
        chk($sformatf("delay%0d_idx1_cycle", units), first_idx, exp_idx);
        chk($sformatf("delay%0d_req_cycle", units), first_req, exp_req);
        wait_end("delay");
        chk($sformatf("delay%0d_writes", units), n_log, 1);
        chk($sformatf("delay%0d_done", units), cfg_done, 1);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h78310311, 8'h78, 16'h3103, 8'h11};
        vecs[1] = '{32'h78300882, 8'h78, 16'h3008, 8'h82};
        vecs[2] = '{32'h783017FF, 8'h78, 16'h3017, 8'hFF};
        vecs[3] = '{32'h6000FF01, 8'h60, 16'h00FF, 8'h01};
        vecs[4] = '{32'h421234A5, 8'h42, 16'h1234, 8'hA5};
        vecs[5] = '{32'h00000000, 8'h00, 16'h0000, 8'h00};
        vecs[6] = '{32'hFDFFFF7E, 8'hFD, 16'hFFFF, 8'h7E};
        vecs[7] = '{32'h308000C3, 8'h30, 16'h8000, 8'hC3};
        foreach (lut[i]) lut[i] = 32'hFF000000;
        foreach (nack_cfg[i]) nack_cfg[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_req", i2c_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_index", lut_index, 0);
        chk("rst_dev", i2c_dev, 0);
        chk("rst_reg", i2c_reg, 0);
        chk("rst_reg2b", i2c_reg_2b, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Two writes then end marker; spurious done pulses in GAP must be ignored
        lut[0] = vecs[0].entry;
        lut[1] = vecs[1].entry;
        lut[2] = 32'hFF000000;
        spur_en = 1'b1;
        epoch++;
        pulse_start();
        chk("t1_busy_after_start", busy, 1);
        chk("t1_index_after_start", lut_index, 0);
        wait_end("t1");
        spur_en = 1'b0;
        chk("t1_writes", n_log, 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t1_dev%0d", i), log_dev[i], vecs[i].dev);
            chk($sformatf("t1_reg%0d", i), log_reg[i], vecs[i].rg);
            chk($sformatf("t1_dat%0d", i), log_dat[i], vecs[i].dat);
        end
        chk("t1_done", cfg_done, 1);
        chk("t1_err", cfg_err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_reg2b", i2c_reg_2b, 1);
        chk("t1_stable", stab_err, 0);

        // Delay commands: 5 units, 1 unit, zero-length
        delay_run(8'd5, 52, 54);
        delay_run(8'd1, 12, 14);
        delay_run(8'd0, 2, 4);

        // Entry 1 always NACKs: 1 + 3 retries then FAIL
        lut[0] = vecs[0].entry;
        lut[1] = vecs[1].entry;
        lut[2] = 32'hFF000000;
        nack_cfg[1] = 99;
        epoch++;
        pulse_start();
        wait_end("t3");
        chk("t3_reqs_idx0", reqs_at[0], 1);
        chk("t3_reqs_idx1", reqs_at[1], 4);
        chk("t3_err", cfg_err, 1);
        chk("t3_done", cfg_done, 0);
        chk("t3_err_index", err_index, 1);
        chk("t3_req_low", i2c_req, 0);

        // Entry 1 NACKs once then ACKs; restart from FAIL clears error state
        nack_cfg[1] = 1;
        epoch++;
        pulse_start();
        chk("t4_err_cleared", cfg_err, 0);
        chk("t4_err_index_cleared", err_index, 0);
        wait_end("t4");
        chk("t4_reqs_idx1", reqs_at[1], 2);
        chk("t4_writes", n_log, 3);
        chk("t4_last_idx", log_idx[2], 1);
        chk("t4_done", cfg_done, 1);
        chk("t4_err", cfg_err, 0);
        nack_cfg[1] = 0;

        // Full 8-entry table with no end marker: stops after the last slot
        foreach (vecs[i]) lut[i] = vecs[i].entry;
        epoch++;
        pulse_start();
        wait_end("t6");
        chk("t6_writes", n_log, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_idx%0d", i), log_idx[i], i);
            chk($sformatf("t6_dev%0d", i), log_dev[i], vecs[i].dev);
            chk($sformatf("t6_reg%0d", i), log_reg[i], vecs[i].rg);
            chk($sformatf("t6_dat%0d", i), log_dat[i], vecs[i].dat);
        end
        chk("t6_done", cfg_done, 1);
        chk("t6_index", lut_index, 7);
        chk("t6_stable", stab_err, 0);

        // start while busy is ignored
        lut[0] = vecs[0].entry;
        lut[1] = vecs[1].entry;
        lut[2] = 32'hFF000000;
        epoch++;
        pulse_start();
        wait_req("t5a");
        pulse_start();
        wait_end("t5a");
        chk("t5_writes", n_log, 2);
        chk("t5_idx0", log_idx[0], 0);
        chk("t5_idx1", log_idx[1], 1);
        chk("t5_done", cfg_done, 1);

        // Asynchronous reset during a request
        epoch++;
        pulse_start();
        wait_req("t5b");
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", i2c_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_index", lut_index, 0);
        chk("t5_rst_done", cfg_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        epoch++;
        pulse_start();
        wait_end("t5c");
        chk("t5_recover_writes", n_log, 2);
        chk("t5_recover_done", cfg_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
